// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load returns onto one
// register-file write port. Optional counters under WB_STATS_EN.
module wb_arbiter #(
  parameter int LD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_waddr,
  input  logic [31:0] ld_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_din,
  output logic        ld_pending
`ifdef WB_STATS_EN
  ,
  output logic [15:0] stat_forced,
  output logic [15:0] stat_drop0
`endif
);

  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_DEPTH);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [36:0]      mem_q [LD_DEPTH];
  logic [36:0]      mem_d [LD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_din_q, rf_din_d;

  logic        empty, full, force_ld, grant_alu, grant_ld, push;
  logic [4:0]  gnt_waddr;
  logic [31:0] gnt_wdata;
  logic [36:0] head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head      = mem_q[rd_ptr_q];
  assign force_ld  = !empty && (starve_q == LIMIT);
  assign grant_alu = !force_ld && alu_valid;
  assign grant_ld  = force_ld || (!alu_valid && !empty);
  assign push      = ld_valid && !full;

  assign alu_ready  = !force_ld;
  assign ld_ready   = !full;
  assign ld_pending = !empty;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_din     = rf_din_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {ld_waddr, ld_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (grant_ld) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, grant_ld})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Counts losses of a waiting head; a granted or absent head resets it.
  always_comb begin
    starve_d = starve_q;
    if (empty || grant_ld) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    gnt_waddr  = grant_ld ? head[36:32] : alu_waddr;
    gnt_wdata  = grant_ld ? head[31:0]  : alu_wdata;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_din_d   = rf_din_q;
    // r0 writes are consumed upstream but never reach the register file.
    if ((grant_alu || grant_ld) && (gnt_waddr != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = gnt_waddr;
      rf_din_d   = gnt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_din_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_din_q   <= rf_din_d;
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] stat_forced_q, stat_forced_d;
  logic [15:0] stat_drop0_q, stat_drop0_d;

  always_comb begin
    stat_forced_d = stat_forced_q;
    stat_drop0_d  = stat_drop0_q;
    if (force_ld && (stat_forced_q != 16'hFFFF)) begin
      stat_forced_d = stat_forced_q + 16'd1;
    end
    if ((grant_alu || grant_ld) && (gnt_waddr == 5'd0) && (stat_drop0_q != 16'hFFFF)) begin
      stat_drop0_d = stat_drop0_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_forced_q <= '0;
      stat_drop0_q  <= '0;
    end else begin
      stat_forced_q <= stat_forced_d;
      stat_drop0_q  <= stat_drop0_d;
    end
  end

  assign stat_forced = stat_forced_q;
  assign stat_drop0  = stat_drop0_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one instance at STARVE_LIMIT=3, one at 15,
// both fed the same stimulus.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        ld_valid;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;

  logic        a_alu_ready, a_ld_ready, a_rf_we, a_ld_pending;
  logic [4:0]  a_rf_waddr;
  logic [31:0] a_rf_din;
  logic        b_alu_ready, b_ld_ready, b_rf_we, b_ld_pending;
  logic [4:0]  b_rf_waddr;
  logic [31:0] b_rf_din;
`ifdef WB_STATS_EN
  logic [15:0] a_stat_forced, a_stat_drop0, b_stat_forced, b_stat_drop0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.LD_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(a_alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_valid(ld_valid), .ld_ready(a_ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .rf_we(a_rf_we), .rf_waddr(a_rf_waddr), .rf_din(a_rf_din), .ld_pending(a_ld_pending)
`ifdef WB_STATS_EN
    , .stat_forced(a_stat_forced), .stat_drop0(a_stat_drop0)
`endif
  );

  wb_arbiter #(.LD_DEPTH(4), .STARVE_LIMIT(15)) dut15 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(b_alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_valid(ld_valid), .ld_ready(b_ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_din(b_rf_din), .ld_pending(b_ld_pending)
`ifdef WB_STATS_EN
    , .stat_forced(b_stat_forced), .stat_drop0(b_stat_drop0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    ld_valid  = 1'b0; ld_waddr  = '0; ld_wdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [4:0]  exp_a [12];
  logic [31:0] exp_d [12];
  int          j, idx;
  logic        pushed;

  initial begin
    exp_a = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    exp_d = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd200, 32'd201,
              32'd202, 32'd203, 32'd204, 32'd205, 32'd206, 32'd207};

    // reset state
    do_reset();
    chk("rst_we", a_rf_we, 0);
    chk("rst_waddr", a_rf_waddr, 0);
    chk("rst_din", a_rf_din, 0);
    chk("rst_pending", a_ld_pending, 0);
    chk("rst_ld_ready", a_ld_ready, 1);

    // ALU write alone
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
    #1;
    chk("alu_ready", a_alu_ready, 1);
    step();
    idle_inputs();
    chk("alu_we", a_rf_we, 1);
    chk("alu_waddr", a_rf_waddr, 5);
    chk("alu_din", a_rf_din, 32'hDEADBEEF);
    step();
    chk("alu_we_off", a_rf_we, 0);
    chk("alu_waddr_hold", a_rf_waddr, 5);

    // load starved by ALU stream, forced after 3 losses
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
    ld_valid = 1'b1; ld_waddr = 5'd7; ld_wdata = 32'd1;
    step();
    ld_valid = 1'b0;
    chk("starve_pending", a_ld_pending, 1);
    chk("starve_alu_w", a_rf_waddr, 3);
    chk("starve_ready0", a_alu_ready, 1);
    step();
    chk("starve_ready1", a_alu_ready, 1);
    step();
    chk("starve_ready2", a_alu_ready, 1);
    step();
    chk("starve_force", a_alu_ready, 0);
    step();
    chk("starve_we", a_rf_we, 1);
    chk("starve_waddr", a_rf_waddr, 7);
    chk("starve_din", a_rf_din, 1);
    chk("starve_after_ready", a_alu_ready, 1);
    chk("starve_empty", a_ld_pending, 0);
`ifdef WB_STATS_EN
    chk("stat_forced", a_stat_forced, 1);
`endif
    alu_valid = 1'b0;

    // FIFO full on the STARVE_LIMIT=15 instance, then drain with wrap-around
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_waddr = 5'(8 + k); ld_wdata = 32'(100 + k);
      step();
    end
    chk("full_ld_ready", b_ld_ready, 0);
    chk("full_pending", b_ld_pending, 1);
    ld_valid = 1'b1; ld_waddr = 5'd12; ld_wdata = 32'd104;
    step();
    chk("full_still", b_ld_ready, 0);
    alu_valid = 1'b0;
    j = 0; idx = 0;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      ld_valid = (j < 8); ld_waddr = 5'(16 + j); ld_wdata = 32'(200 + j);
      #1;
      pushed = ld_valid && b_ld_ready;
      step();
      if (pushed) j++;
      if (b_rf_we) begin
        if (idx < 12) begin
          chk("drain_waddr", b_rf_waddr, exp_a[idx]);
          chk("drain_din", b_rf_din, exp_d[idx]);
        end
        idx++;
      end
    end
    ld_valid = 1'b0;
    chk("drain_count", idx, 12);
    step();
    chk("drain_empty", b_ld_pending, 0);

    // r0 suppression
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h55;
    #1;
    chk("r0_ready", a_alu_ready, 1);
    step();
    idle_inputs();
    chk("r0_we", a_rf_we, 0);
    step();
    chk("r0_we2", a_rf_we, 0);
`ifdef WB_STATS_EN
    chk("stat_drop0", a_stat_drop0, 1);
`endif

    // reset mid-operation
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = 32'd9;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_waddr = 5'(24 + k); ld_wdata = 32'(300 + k);
      step();
    end
    chk("mid_pending", a_ld_pending, 1);
    chk("mid_we", a_rf_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", a_rf_we, 0);
    chk("mid_rst_pending", a_ld_pending, 0);
    chk("mid_rst_ld_ready", a_ld_ready, 1);
    idle_inputs();
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_after_we", a_rf_we, 0);
    end

    // simultaneous push and pop with two entries held
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd0;
    ld_valid = 1'b1; ld_waddr = 5'd1; ld_wdata = 32'hA0;
    step();
    ld_waddr = 5'd2; ld_wdata = 32'hB0;
    step();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_waddr = 5'(3 + i); ld_wdata = 32'(32'hC0 + 32'h10 * i);
      step();
      chk("pp_we", a_rf_we, 1);
      chk("pp_waddr", a_rf_waddr, 32'(1 + i));
      chk("pp_din", a_rf_din, 32'(32'hA0 + 32'h10 * i));
      chk("pp_ld_ready", a_ld_ready, 1);
    end
    ld_valid = 1'b0;
    chk("pp_pending", a_ld_pending, 1);
    step();
    chk("pp_next_waddr", a_rf_waddr, 5);
    step();
    chk("pp_last_waddr", a_rf_waddr, 6);
    chk("pp_last_din", a_rf_din, 32'hF0);
    chk("pp_drained", a_ld_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
